// File: rtl/calf_eject_reasm_pkg.sv
// Shared definitions for the CALF ejection-side reassembly block.
// Ejected flit word layout (ControlW bits):
//   [143:16] data, [15:12] MSHR, [11] valid, [10:8] seq, [7:4] source, [3:0] dest.
// The reassembly key is {source, MSHR}.
package calf_eject_reasm_pkg;

  localparam int unsigned ControlW = 144;
  localparam int unsigned DataW    = 128;
  localparam int unsigned DataLsb  = 16;
  localparam int unsigned MshrLsb  = 12;
  localparam int unsigned ValidBit = 11;
  localparam int unsigned SeqLsb   = 8;
  localparam int unsigned SrcLsb   = 4;
  localparam int unsigned DestLsb  = 0;
  localparam int unsigned KeyW     = 8;

  typedef enum logic [1:0] {
    SlotFree,
    SlotFill,
    SlotDone
  } slot_state_e;

  // Reassembly key {source, MSHR} of an ejected flit word.
  function automatic logic [KeyW-1:0] flit_key(input logic [ControlW-1:0] flit);
    return {flit[SrcLsb +: 4], flit[MshrLsb +: 4]};
  endfunction

endpackage

// File: rtl/calf_reasm_slot.sv
// One reassembly slot: state, key, receive mask and per-seq data storage.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   alloc_i           claim this FREE slot for key_i, storing the first flit
//   wr_i              store a flit for the already-matched key (ignored unless FILL)
//   free_i            release the slot after packet handshake
//   key_i/seq_i/data_i  incoming flit fields
//   state_o, key_o    current slot state and key
//   seen_o            mask bit for seq_i already set (duplicate detect)
//   data_o            packet payload, seq k at [k*DataW +: DataW]
module calf_reasm_slot
  import calf_eject_reasm_pkg::*;
#(
  parameter int unsigned PktFlits = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_i,
  input  logic                      wr_i,
  input  logic                      free_i,
  input  logic [KeyW-1:0]           key_i,
  input  logic [2:0]                seq_i,
  input  logic [DataW-1:0]          data_i,
  output slot_state_e               state_o,
  output logic [KeyW-1:0]           key_o,
  output logic                      seen_o,
  output logic [PktFlits*DataW-1:0] data_o
);

  slot_state_e                        state_q, state_d;
  logic        [KeyW-1:0]             key_q, key_d;
  logic        [PktFlits-1:0]         mask_q, mask_d;
  logic        [PktFlits-1:0][DataW-1:0] data_q, data_d;
  logic        [PktFlits-1:0]         seq_hot;

  always_comb begin
    seq_hot = '0;
    for (int k = 0; k < int'(PktFlits); k++) begin
      seq_hot[k] = (seq_i == 3'(k));
    end
    seen_o  = |(mask_q & seq_hot);

    state_d = state_q;
    key_d   = key_q;
    mask_d  = mask_q;
    data_d  = data_q;

    if (free_i) begin
      state_d = SlotFree;
      mask_d  = '0;
    end else if (alloc_i || (wr_i && state_q == SlotFill)) begin
      if (alloc_i) begin
        key_d  = key_i;
        mask_d = seq_hot;
      end else begin
        mask_d = mask_q | seq_hot;
      end
      for (int k = 0; k < int'(PktFlits); k++) begin
        if (seq_hot[k]) data_d[k] = data_i;
      end
      // Single-flit packets go straight to DONE on allocation.
      state_d = (&mask_d) ? SlotDone : SlotFill;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SlotFree;
      key_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
    end
  end

  // Payload is only visible while DONE, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign state_o = state_q;
  assign key_o   = key_q;
  assign data_o  = data_q;

endmodule

// File: rtl/calf_eject_reasm.sv
// CALF ejection-port packet reassembly. Consumes one flit per cycle from the
// router ejection port and rebuilds multi-flit packets keyed by {source, MSHR}.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   eject_ci                      ejected flit word
//   pkt_valid/pkt_ready           completed-packet handshake
//   pkt_src, pkt_mshr, pkt_data   presented packet (zero when none)
//   err_misroute/overflow/dup     one-cycle error pulses
//   drop_cnt                      saturating misroute + overflow drop count
module calf_eject_reasm
  import calf_eject_reasm_pkg::*;
#(
  parameter logic [3:0]  NODE_ID   = 4'h7,
  parameter int unsigned PKT_FLITS = 4,
  parameter int unsigned NSLOTS    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ControlW-1:0]        eject_ci,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [3:0]                 pkt_src,
  output logic [3:0]                 pkt_mshr,
  output logic [PKT_FLITS*DataW-1:0] pkt_data,
  output logic                       err_misroute,
  output logic                       err_overflow,
  output logic                       err_dup,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned IdxW = $clog2(NSLOTS);

  // Flit fields.
  logic              f_valid;
  logic [2:0]        f_seq;
  logic [3:0]        f_dest;
  logic [KeyW-1:0]   f_key;
  logic [DataW-1:0]  f_data;

  assign f_valid = eject_ci[ValidBit];
  assign f_seq   = eject_ci[SeqLsb +: 3];
  assign f_dest  = eject_ci[DestLsb +: 4];
  assign f_key   = flit_key(eject_ci);
  assign f_data  = eject_ci[DataLsb +: DataW];

  // Per-slot signals.
  slot_state_e                slot_st   [NSLOTS];
  logic [KeyW-1:0]            slot_key  [NSLOTS];
  logic [PKT_FLITS*DataW-1:0] slot_data [NSLOTS];
  logic [NSLOTS-1:0]          slot_seen, slot_alloc, slot_wr, slot_rel;
  logic [NSLOTS-1:0]          slot_free, slot_done, match;

  for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
    calf_reasm_slot #(
      .PktFlits(PKT_FLITS)
    ) u_slot (
      .clk_i  (clk),
      .rst_i  (rst),
      .alloc_i(slot_alloc[i]),
      .wr_i   (slot_wr[i]),
      .free_i (slot_rel[i]),
      .key_i  (f_key),
      .seq_i  (f_seq),
      .data_i (f_data),
      .state_o(slot_st[i]),
      .key_o  (slot_key[i]),
      .seen_o (slot_seen[i]),
      .data_o (slot_data[i])
    );
  end

  // Key CAM, allocation and error classification.
  logic misroute, f_ok, hit, overflow, dup;
  logic [NSLOTS-1:0] free_oh;

  always_comb begin
    for (int i = 0; i < int'(NSLOTS); i++) begin
      slot_free[i] = (slot_st[i] == SlotFree);
      slot_done[i] = (slot_st[i] == SlotDone);
      match[i]     = !slot_free[i] && (slot_key[i] == f_key);
    end
    misroute = f_valid && ((f_dest != NODE_ID) || ({29'b0, f_seq} >= PKT_FLITS));
    f_ok     = f_valid && !misroute;
    hit      = |match;
    // Lowest-index FREE slot as one-hot. A slot released this cycle is still
    // DONE here, so it cannot be reallocated until the next cycle.
    free_oh    = slot_free & (~slot_free + NSLOTS'(1));
    slot_alloc = (f_ok && !hit) ? free_oh : '0;
    slot_wr    = f_ok ? (match & ~slot_done) : '0;
    overflow   = f_ok && !hit && !(|slot_free);
    // A hit on a DONE slot always reports seen, since its mask is full.
    dup        = f_ok && |(match & slot_seen);
  end

  // Output selection: lowest DONE slot, held while presented and not accepted.
  logic             hold_q, hold_d;
  logic [IdxW-1:0]  held_idx_q, held_idx_d;
  logic [IdxW-1:0]  done_idx, cur_idx;

  always_comb begin
    done_idx = '0;
    for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
      if (slot_done[i]) done_idx = IdxW'(i);
    end
    cur_idx    = hold_q ? held_idx_q : done_idx;
    pkt_valid  = |slot_done;
    pkt_src    = pkt_valid ? slot_key[cur_idx][7:4] : '0;
    pkt_mshr   = pkt_valid ? slot_key[cur_idx][3:0] : '0;
    pkt_data   = pkt_valid ? slot_data[cur_idx] : '0;
    slot_rel   = (pkt_valid && pkt_ready) ? (NSLOTS'(1) << cur_idx) : '0;
    hold_d     = pkt_valid && !pkt_ready;
    held_idx_d = cur_idx;
  end

  // Error pulses and drop counter.
  logic        err_misroute_q, err_misroute_d;
  logic        err_overflow_q, err_overflow_d;
  logic        err_dup_q, err_dup_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    err_misroute_d = misroute;
    err_overflow_d = overflow;
    err_dup_d      = dup;
    drop_cnt_d     = drop_cnt_q;
    if ((misroute || overflow) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q         <= 1'b0;
      held_idx_q     <= '0;
      err_misroute_q <= 1'b0;
      err_overflow_q <= 1'b0;
      err_dup_q      <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      hold_q         <= hold_d;
      held_idx_q     <= held_idx_d;
      err_misroute_q <= err_misroute_d;
      err_overflow_q <= err_overflow_d;
      err_dup_q      <= err_dup_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign err_misroute = err_misroute_q;
  assign err_overflow = err_overflow_q;
  assign err_dup      = err_dup_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_calf_eject_reasm.sv
// Directed bench for calf_eject_reasm (NODE_ID=7, PKT_FLITS=4, NSLOTS=4).
module tb_calf_eject_reasm;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [143:0] eject_ci = '0;
  logic         pkt_ready = 1'b0;
  logic         pkt_valid;
  logic [3:0]   pkt_src, pkt_mshr;
  logic [511:0] pkt_data;
  logic         err_misroute, err_overflow, err_dup;
  logic [15:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  calf_eject_reasm #(
    .NODE_ID  (4'h7),
    .PKT_FLITS(4),
    .NSLOTS   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .eject_ci    (eject_ci),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_src     (pkt_src),
    .pkt_mshr    (pkt_mshr),
    .pkt_data    (pkt_data),
    .err_misroute(err_misroute),
    .err_overflow(err_overflow),
    .err_dup     (err_dup),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] dv(input logic [7:0] key, input logic [2:0] seq);
    return {32'hFEED_0000, 24'h0, key, 32'h5A5A_0000, 29'h0, seq};
  endfunction

  function automatic logic [511:0] pk(input logic [7:0] key);
    return {dv(key, 3'd3), dv(key, 3'd2), dv(key, 3'd1), dv(key, 3'd0)};
  endfunction

  // key = {src, mshr}
  function automatic logic [143:0] fl(input logic [7:0] key, input logic [2:0] seq,
                                      input logic [3:0] dest, input logic [127:0] data);
    return {data, key[3:0], 1'b1, seq, key[7:4], dest};
  endfunction

  function automatic logic [143:0] fk(input logic [7:0] key, input logic [2:0] seq);
    return fl(key, seq, 4'h7, dv(key, seq));
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic m, input logic o, input logic d,
                         input logic [15:0] cnt);
    chk({tag, ".misroute"}, 512'(err_misroute), 512'(m));
    chk({tag, ".overflow"}, 512'(err_overflow), 512'(o));
    chk({tag, ".dup"},      512'(err_dup),      512'(d));
    chk({tag, ".drop_cnt"}, 512'(drop_cnt),     512'(cnt));
  endtask

  task automatic chk_pkt(input string tag, input logic [3:0] src, input logic [3:0] mshr,
                         input logic [511:0] data);
    chk({tag, ".valid"}, 512'(pkt_valid), 512'(1'b1));
    chk({tag, ".src"},   512'(pkt_src),   512'(src));
    chk({tag, ".mshr"},  512'(pkt_mshr),  512'(mshr));
    chk({tag, ".data"},  pkt_data,        data);
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic [143:0] f, input logic rdy);
    eject_ci  = f;
    pkt_ready = rdy;
    @(posedge clk);
    #1;
    eject_ci  = '0;
    pkt_ready = 1'b0;
  endtask

  logic [511:0] exp_data;
  logic [143:0] bad_flit;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 512'(pkt_valid), 512'(1'b0));
    chk("rst.src", 512'(pkt_src), 512'(4'h0));
    chk("rst.mshr", 512'(pkt_mshr), 512'(4'h0));
    chk("rst.data", pkt_data, 512'h0);
    chk_err("rst", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    // In-order packet, src 5 / mshr 1
    cyc(fk(8'h51, 3'd0), 1'b0);
    cyc(fk(8'h51, 3'd1), 1'b0);
    cyc(fk(8'h51, 3'd2), 1'b0);
    chk("a.before_last", 512'(pkt_valid), 512'(1'b0));
    cyc(fk(8'h51, 3'd3), 1'b0);
    chk_pkt("a.done", 4'h5, 4'h1, pk(8'h51));
    chk_err("a.done", 1'b0, 1'b0, 1'b0, 16'd0);
    cyc('0, 1'b0);
    chk_pkt("a.held", 4'h5, 4'h1, pk(8'h51));
    cyc('0, 1'b1);
    chk("a.accepted", 512'(pkt_valid), 512'(1'b0));

    // Interleaved, out of order: 0x51 -> slot0, 0x42 -> slot1
    cyc(fk(8'h51, 3'd2), 1'b0);
    cyc(fk(8'h42, 3'd0), 1'b0);
    cyc(fk(8'h42, 3'd3), 1'b0);
    cyc(fk(8'h51, 3'd0), 1'b0);
    cyc(fk(8'h51, 3'd3), 1'b0);
    cyc(fk(8'h42, 3'd1), 1'b0);
    chk("b.none_done", 512'(pkt_valid), 512'(1'b0));
    cyc(fk(8'h42, 3'd2), 1'b0);
    chk_pkt("b.slot1", 4'h4, 4'h2, pk(8'h42));
    // Lower slot completes while slot1 is held: presentation must not change
    cyc(fk(8'h51, 3'd1), 1'b0);
    chk_pkt("b.stable", 4'h4, 4'h2, pk(8'h42));
    cyc('0, 1'b1);
    chk_pkt("b.next", 4'h5, 4'h1, pk(8'h51));
    cyc('0, 1'b1);
    chk("b.empty", 512'(pkt_valid), 512'(1'b0));
    chk_err("b.end", 1'b0, 1'b0, 1'b0, 16'd0);

    // Misroutes: wrong dest, then seq out of range
    bad_flit = 144'h284c;
    cyc(bad_flit, 1'b0);
    chk_err("c.dest", 1'b1, 1'b0, 1'b0, 16'd1);
    chk("c.dest.valid", 512'(pkt_valid), 512'(1'b0));
    cyc('0, 1'b0);
    chk_err("c.pulse_end", 1'b0, 1'b0, 1'b0, 16'd1);
    cyc(fk(8'h61, 3'd5), 1'b0);
    chk_err("c.seq", 1'b1, 1'b0, 1'b0, 16'd2);

    // Overflow: four partial packets fill every slot
    cyc(fk(8'h11, 3'd0), 1'b0);
    cyc(fk(8'h12, 3'd0), 1'b0);
    cyc(fk(8'h13, 3'd0), 1'b0);
    cyc(fk(8'h14, 3'd0), 1'b0);
    chk_err("d.fourth", 1'b0, 1'b0, 1'b0, 16'd2);
    cyc(fk(8'h15, 3'd0), 1'b0);
    chk_err("d.ovf", 1'b0, 1'b1, 1'b0, 16'd3);
    cyc(fk(8'h11, 3'd1), 1'b0);
    cyc(fk(8'h11, 3'd2), 1'b0);
    cyc(fk(8'h11, 3'd3), 1'b0);
    chk_pkt("d.done", 4'h1, 4'h1, pk(8'h11));
    // Slot freed by this handshake is not yet allocatable
    cyc(fk(8'h15, 3'd0), 1'b1);
    chk_err("d.ovf_at_free", 1'b0, 1'b1, 1'b0, 16'd4);
    chk("d.freed", 512'(pkt_valid), 512'(1'b0));
    cyc(fk(8'h15, 3'd0), 1'b0);
    chk_err("d.alloc", 1'b0, 1'b0, 1'b0, 16'd4);

    // Duplicates: FILL slot overwrite, then DONE slot frozen
    cyc(fk(8'h12, 3'd2), 1'b0);
    chk_err("e.first", 1'b0, 1'b0, 1'b0, 16'd4);
    cyc(fl(8'h12, 3'd2, 4'h7, ~dv(8'h12, 3'd2)), 1'b0);
    chk_err("e.dup_fill", 1'b0, 1'b0, 1'b1, 16'd4);
    cyc(fk(8'h12, 3'd1), 1'b0);
    chk("e.dup_pulse_end", 512'(err_dup), 512'(1'b0));
    cyc(fk(8'h12, 3'd3), 1'b0);
    exp_data = pk(8'h12);
    exp_data[256 +: 128] = ~dv(8'h12, 3'd2);
    chk_pkt("e.done", 4'h1, 4'h2, exp_data);
    cyc(fl(8'h12, 3'd1, 4'h7, 128'hBAD), 1'b0);
    chk_err("e.dup_done", 1'b0, 1'b0, 1'b1, 16'd4);
    chk_pkt("e.frozen", 4'h1, 4'h2, exp_data);
    cyc('0, 1'b1);
    chk("e.accepted", 512'(pkt_valid), 512'(1'b0));

    // Reset with three partial slots (0x15, 0x13, 0x14) and one DONE
    cyc(fk(8'h13, 3'd1), 1'b0);
    cyc(fk(8'h13, 3'd2), 1'b0);
    cyc(fk(8'h13, 3'd3), 1'b0);
    chk_pkt("f.done", 4'h1, 4'h3, pk(8'h13));
    rst = 1'b1;
    cyc(bad_flit, 1'b0);
    chk("f.rst.valid", 512'(pkt_valid), 512'(1'b0));
    chk_err("f.rst", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    cyc('0, 1'b0);
    chk_err("f.after", 1'b0, 1'b0, 1'b0, 16'd0);
    // Old seq0 of 0x14 must be gone: seq1..3 alone cannot complete
    cyc(fk(8'h14, 3'd1), 1'b0);
    cyc(fk(8'h14, 3'd2), 1'b0);
    cyc(fk(8'h14, 3'd3), 1'b0);
    chk("f.partial", 512'(pkt_valid), 512'(1'b0));
    cyc(fk(8'h14, 3'd0), 1'b0);
    chk_pkt("f.fresh", 4'h1, 4'h4, pk(8'h14));
    chk_err("f.fresh", 1'b0, 1'b0, 1'b0, 16'd0);
    cyc('0, 1'b1);
    chk("f.accepted", 512'(pkt_valid), 512'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
